dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-cycle sequencer in front of the data memory.
// Port 0 is the core load/store path; port 1 is the DMA/debug loader.
module dmem_arbiter #(
    parameter int unsigned Width     = 32,
    parameter int unsigned AddrWidth = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [Width-1:0] req_addr_0,
    input  logic [Width-1:0] req_wdata_0,
    input  logic [2:0]       req_mode_0,
    output logic             rsp_valid_0,
    output logic [Width-1:0] rsp_rdata_0,
    output logic             rsp_err_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [Width-1:0] req_addr_1,
    input  logic [Width-1:0] req_wdata_1,
    input  logic [2:0]       req_mode_1,
    output logic             rsp_valid_1,
    output logic [Width-1:0] rsp_rdata_1,
    output logic             rsp_err_1,
    output logic [Width-1:0] mem_addr,
    output logic [Width-1:0] mem_wdata,
    output logic [2:0]       mem_mode,
    output logic             mem_write,
    output logic             mem_read,
    input  logic [Width-1:0] mem_rdata
);

    localparam logic [2:0] MODE_LH        = 3'b001;
    localparam logic [2:0] MODE_LW        = 3'b010;
    localparam logic [2:0] MODE_LHU       = 3'b100;
    localparam logic [2:0] MODE_SH        = 3'b110;
    localparam logic [2:0] MODE_SW        = 3'b111;
    localparam logic [2:0] MODE_LAST_LOAD = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             cap_port_q, cap_port_d;
    logic [Width-1:0] cap_addr_q, cap_addr_d;
    logic [Width-1:0] cap_wdata_q, cap_wdata_d;
    logic [2:0]       cap_mode_q, cap_mode_d;
    logic             cap_err_q, cap_err_d;
    logic [Width-1:0] rsp_rdata_0_q, rsp_rdata_0_d;
    logic [Width-1:0] rsp_rdata_1_q, rsp_rdata_1_d;
    logic             rsp_err_0_q, rsp_err_0_d;
    logic             rsp_err_1_q, rsp_err_1_d;

    logic             arb_en;
    logic             win_0;
    logic             win_1;
    logic             accept;
    logic             mem_en;
    logic             cap_is_load;
    logic [Width-1:0] sel_addr;
    logic [Width-1:0] sel_wdata;
    logic [2:0]       sel_mode;
    logic [Width-1:0] load_data;

    // Rejects misaligned halfword/word accesses and addresses beyond the implemented range.
    function automatic logic access_err(input logic [2:0] mode, input logic [Width-1:0] addr);
        logic half_bad;
        logic word_bad;
        logic range_bad;
        half_bad  = ((mode == MODE_LH) || (mode == MODE_LHU) || (mode == MODE_SH)) && addr[0];
        word_bad  = ((mode == MODE_LW) || (mode == MODE_SW)) && (addr[1:0] != 2'b00);
        range_bad = (addr[Width-1:AddrWidth] != '0);
        return half_bad | word_bad | range_bad;
    endfunction

    // Round-robin: on a tie the port that did not win last time is granted.
    always_comb begin
        arb_en    = (state_q != ACCESS) && !reset;
        win_0     = arb_en && req_valid_0 && (!req_valid_1 || last_grant_q);
        win_1     = arb_en && req_valid_1 && (!req_valid_0 || !last_grant_q);
        accept    = win_0 | win_1;
        sel_addr  = win_1 ? req_addr_1  : req_addr_0;
        sel_wdata = win_1 ? req_wdata_1 : req_wdata_0;
        sel_mode  = win_1 ? req_mode_1  : req_mode_0;
    end

    assign cap_is_load = (cap_mode_q <= MODE_LAST_LOAD);
    assign load_data   = (cap_is_load && !cap_err_q) ? mem_rdata : '0;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cap_port_d    = cap_port_q;
        cap_addr_d    = cap_addr_q;
        cap_wdata_d   = cap_wdata_q;
        cap_mode_d    = cap_mode_q;
        cap_err_d     = cap_err_q;
        rsp_rdata_0_d = rsp_rdata_0_q;
        rsp_rdata_1_d = rsp_rdata_1_q;
        rsp_err_0_d   = rsp_err_0_q;
        rsp_err_1_d   = rsp_err_1_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d      = ACCESS;
                    last_grant_d = win_1;
                    cap_port_d   = win_1;
                    cap_addr_d   = sel_addr;
                    cap_wdata_d  = sel_wdata;
                    cap_mode_d   = sel_mode;
                    cap_err_d    = access_err(sel_mode, sel_addr);
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (cap_port_q) begin
                    rsp_rdata_1_d = load_data;
                    rsp_err_1_d   = cap_err_q;
                end else begin
                    rsp_rdata_0_d = load_data;
                    rsp_err_0_d   = cap_err_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            cap_port_q    <= 1'b0;
            cap_addr_q    <= '0;
            cap_wdata_q   <= '0;
            cap_mode_q    <= '0;
            cap_err_q     <= 1'b0;
            rsp_rdata_0_q <= '0;
            rsp_rdata_1_q <= '0;
            rsp_err_0_q   <= 1'b0;
            rsp_err_1_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cap_port_q    <= cap_port_d;
            cap_addr_q    <= cap_addr_d;
            cap_wdata_q   <= cap_wdata_d;
            cap_mode_q    <= cap_mode_d;
            cap_err_q     <= cap_err_d;
            rsp_rdata_0_q <= rsp_rdata_0_d;
            rsp_rdata_1_q <= rsp_rdata_1_d;
            rsp_err_0_q   <= rsp_err_0_d;
            rsp_err_1_q   <= rsp_err_1_d;
        end
    end

    // Memory and handshake strobes are gated by reset so an in-flight store or pulse is dropped.
    assign mem_en      = (state_q == ACCESS) && !reset;
    assign mem_addr    = mem_en ? cap_addr_q  : '0;
    assign mem_wdata   = mem_en ? cap_wdata_q : '0;
    assign mem_mode    = mem_en ? cap_mode_q  : 3'b000;
    assign mem_read    = mem_en && cap_is_load && !cap_err_q;
    assign mem_write   = mem_en && !cap_is_load && !cap_err_q;

    assign req_ready_0 = win_0;
    assign req_ready_1 = win_1;
    assign rsp_valid_0 = (state_q == RESP) && !cap_port_q && !reset;
    assign rsp_valid_1 = (state_q == RESP) && cap_port_q && !reset;
    assign rsp_rdata_0 = rsp_rdata_0_q;
    assign rsp_rdata_1 = rsp_rdata_1_q;
    assign rsp_err_0   = rsp_err_0_q;
    assign rsp_err_1   = rsp_err_1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian 32-byte memory model behind it.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_addr_0, req_addr_1;
    logic [31:0] req_wdata_0, req_wdata_1;
    logic [2:0]  req_mode_0, req_mode_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_rdata_0, rsp_rdata_1;
    logic        rsp_err_0, rsp_err_1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_mode;
    logic        mem_write, mem_read;

    int checks   = 0;
    int failures = 0;

    // Observations recorded by run_txn
    int          o_wait, o_lat;
    logic        o_acc, o_rsp, o_other_rsp, o_mem_any, o_mwr, o_mrd, o_err;
    logic [2:0]  o_mmode;
    logic [31:0] o_maddr, o_mwdata, o_rdata;

    dmem_arbiter #(.Width(32), .AddrWidth(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_addr_0(req_addr_0),
        .req_wdata_0(req_wdata_0), .req_mode_0(req_mode_0),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_addr_1(req_addr_1),
        .req_wdata_1(req_wdata_1), .req_mode_1(req_mode_1),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read with sign/zero extension, store on rising edge
    logic [7:0] mem [32] = '{default: 8'h00};
    logic [4:0] ma;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        ma = mem_addr[4:0];
        b0 = mem[ma];
        b1 = mem[ma + 5'd1];
        b2 = mem[ma + 5'd2];
        b3 = mem[ma + 5'd3];
        case (mem_mode)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rdata = {b3, b2, b1, b0};
            3'b011:  mem_rdata = {24'h0, b0};
            3'b100:  mem_rdata = {16'h0, b1, b0};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[ma] <= mem_wdata[7:0];
            if (mem_mode != 3'b101) mem[ma + 5'd1] <= mem_wdata[15:8];
            if (mem_mode == 3'b111) begin
                mem[ma + 5'd2] <= mem_wdata[23:16];
                mem[ma + 5'd3] <= mem_wdata[31:24];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int p, input logic v, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            req_valid_0 = v; req_mode_0 = m; req_addr_0 = a; req_wdata_0 = wd;
        end else begin
            req_valid_1 = v; req_mode_1 = m; req_addr_1 = a; req_wdata_1 = wd;
        end
    endtask

    function automatic logic ready_of(input int p);
        return (p == 0) ? req_ready_0 : req_ready_1;
    endfunction

    function automatic logic rsp_of(input int p);
        return (p == 0) ? rsp_valid_0 : rsp_valid_1;
    endfunction

    // Issues one request and records handshake, memory and response observations.
    task automatic run_txn(input int p, input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd);
        o_wait = 0; o_lat = 0; o_acc = 0; o_rsp = 0; o_other_rsp = 0; o_mem_any = 0;
        o_rdata = 32'hx; o_err = 1'bx;
        drive(p, 1'b1, m, a, wd);
        for (int i = 0; i < 8; i++) begin
            #1;
            o_mem_any |= mem_read | mem_write;
            if (ready_of(p)) begin
                o_acc = 1'b1;
                break;
            end
            o_wait++;
            cyc();
        end
        cyc();
        drive(p, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        o_mwr = mem_write; o_mrd = mem_read; o_mmode = mem_mode;
        o_maddr = mem_addr; o_mwdata = mem_wdata;
        o_mem_any |= mem_read | mem_write;
        for (int j = 0; j < 6; j++) begin
            cyc();
            #1;
            o_mem_any |= mem_read | mem_write;
            o_other_rsp |= rsp_of(1 - p);
            if (rsp_of(p)) begin
                o_rsp = 1'b1;
                o_lat = j + 2;
                o_rdata = (p == 0) ? rsp_rdata_0 : rsp_rdata_1;
                o_err = (p == 0) ? rsp_err_0 : rsp_err_1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc();
        drive(0, 1'b1, 3'b010, 32'h0, 32'h0);
        drive(1, 1'b1, 3'b010, 32'h0, 32'h0);
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b00) begin
            failures++; $display("FAIL reset_ready: got %b required 00", {req_ready_0, req_ready_1});
        end
        checks++;
        if ({rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1} !== 4'b0000) begin
            failures++; $display("FAIL reset_rsp_flags: got %b required 0000", {rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1});
        end
        checks++;
        if ({rsp_rdata_0, rsp_rdata_1} !== 64'h0) begin
            failures++; $display("FAIL reset_rsp_rdata: got %h required 0", {rsp_rdata_0, rsp_rdata_1});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_mode, mem_write, mem_read} !== 69'h0) begin
            failures++; $display("FAIL reset_mem: got %h required 0", {mem_addr, mem_wdata, mem_mode, mem_write, mem_read});
        end
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        run_txn(0, 3'b111, 32'h4, 32'hDEADBEEF);
        checks++;
        if ({o_acc, o_wait} !== {1'b1, 32'd0}) begin
            failures++; $display("FAIL sw_accept: acc=%b wait=%0d required acc=1 wait=0", o_acc, o_wait);
        end
        checks++;
        if ({o_mwr, o_mrd, o_mmode, o_maddr, o_mwdata} !== {1'b1, 1'b0, 3'b111, 32'h4, 32'hDEADBEEF}) begin
            failures++; $display("FAIL sw_mem: wr=%b rd=%b mode=%b addr=%h wdata=%h required 1 0 111 4 deadbeef",
                                 o_mwr, o_mrd, o_mmode, o_maddr, o_mwdata);
        end
        checks++;
        if ({o_rsp, o_lat, o_err, o_rdata} !== {1'b1, 32'd2, 1'b0, 32'h0}) begin
            failures++; $display("FAIL sw_rsp: rsp=%b lat=%0d err=%b rdata=%h required 1 2 0 0", o_rsp, o_lat, o_err, o_rdata);
        end
        run_txn(0, 3'b010, 32'h4, 32'h0);
        checks++;
        if ({o_acc, o_wait, o_mrd, o_mwr} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL lw_accept_mem: acc=%b wait=%0d rd=%b wr=%b required 1 0 1 0", o_acc, o_wait, o_mrd, o_mwr);
        end
        checks++;
        if ({o_rsp, o_lat, o_err, o_rdata} !== {1'b1, 32'd2, 1'b0, 32'hDEADBEEF}) begin
            failures++; $display("FAIL lw_rsp: rsp=%b lat=%0d err=%b rdata=%h required 1 2 0 deadbeef", o_rsp, o_lat, o_err, o_rdata);
        end
        cyc();
        #1;
        checks++;
        if ({rsp_valid_0, rsp_rdata_0} !== {1'b0, 32'hDEADBEEF}) begin
            failures++; $display("FAIL rsp_hold: valid=%b rdata=%h required 0 deadbeef", rsp_valid_0, rsp_rdata_0);
        end
    endtask

    task automatic test_sign_ext();
        run_txn(0, 3'b111, 32'h4, 32'h80000000);
        run_txn(0, 3'b000, 32'h7, 32'h0);
        checks++;
        if ({o_rsp, o_err, o_rdata} !== {1'b1, 1'b0, 32'hFFFFFF80}) begin
            failures++; $display("FAIL lb_sext: rsp=%b err=%b rdata=%h required 1 0 ffffff80", o_rsp, o_err, o_rdata);
        end
        run_txn(0, 3'b011, 32'h7, 32'h0);
        checks++;
        if ({o_rsp, o_err, o_rdata} !== {1'b1, 1'b0, 32'h00000080}) begin
            failures++; $display("FAIL lbu_zext: rsp=%b err=%b rdata=%h required 1 0 00000080", o_rsp, o_err, o_rdata);
        end
    endtask

    task automatic test_contention();
        logic [7:0] r0, r1, v0, v1;
        r0 = '0; r1 = '0; v0 = '0; v1 = '0;
        reset = 1'b1;
        drive(0, 1'b1, 3'b010, 32'h0, 32'h0);
        drive(1, 1'b1, 3'b010, 32'h0, 32'h0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            r0[k] = req_ready_0; r1[k] = req_ready_1;
            v0[k] = rsp_valid_0; v1[k] = rsp_valid_1;
            cyc();
        end
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc();
        checks++;
        if ({r0, r1} !== {8'h11, 8'h44}) begin
            failures++; $display("FAIL rr_grants: ready0=%b ready1=%b required 00010001 01000100", r0, r1);
        end
        checks++;
        if ({v0, v1} !== {8'h44, 8'h10}) begin
            failures++; $display("FAIL rr_rsp: rsp0=%b rsp1=%b required 01000100 00010000", v0, v1);
        end
        checks++;
        if ((v0 & v1) !== 8'h00) begin
            failures++; $display("FAIL rr_rsp_overlap: got %b required 00000000", v0 & v1);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  modes [3];
        logic [31:0] addrs [3];
        modes[0] = 3'b001; addrs[0] = 32'h3;
        modes[1] = 3'b111; addrs[1] = 32'h6;
        modes[2] = 3'b010; addrs[2] = 32'h40;
        for (int i = 0; i < 3; i++) begin
            run_txn(0, modes[i], addrs[i], 32'hCAFEF00D);
            checks++;
            if ({o_acc, o_rsp, o_lat, o_err, o_rdata, o_mem_any} !== {1'b1, 1'b1, 32'd2, 1'b1, 32'h0, 1'b0}) begin
                failures++; $display("FAIL err_%0d: acc=%b rsp=%b lat=%0d err=%b rdata=%h mem_any=%b required 1 1 2 1 0 0",
                                     i, o_acc, o_rsp, o_lat, o_err, o_rdata, o_mem_any);
            end
        end
    endtask

    task automatic test_reset_access();
        logic seen;
        drive(1, 1'b1, 3'b101, 32'h1, 32'h000000AB);
        #1;
        checks++;
        if (req_ready_1 !== 1'b1) begin
            failures++; $display("FAIL sb_accept: got %b required 1", req_ready_1);
        end
        cyc();
        drive(1, 1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_write, mem_read} !== 2'b00) begin
            failures++; $display("FAIL reset_access_mem: got %b required 00", {mem_write, mem_read});
        end
        cyc();
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            seen |= rsp_valid_1;
            cyc();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL reset_access_rsp: got %b required 0", seen);
        end
        drive(0, 1'b1, 3'b010, 32'h0, 32'h0);
        drive(1, 1'b1, 3'b010, 32'h0, 32'h0);
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            failures++; $display("FAIL tie_after_reset: got %b required 10", {req_ready_0, req_ready_1});
        end
        cyc();
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
        run_txn(1, 3'b011, 32'h1, 32'h0);
        checks++;
        if ({o_rsp, o_err, o_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            failures++; $display("FAIL lbu_after_drop: rsp=%b err=%b rdata=%h required 1 0 0", o_rsp, o_err, o_rdata);
        end
        // Reset landing on a response cycle must swallow the pulse.
        cyc();
        drive(0, 1'b1, 3'b010, 32'h4, 32'h0);
        cyc();
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc();
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid_0 !== 1'b0) begin
            failures++; $display("FAIL reset_resp_pulse: got %b required 0", rsp_valid_0);
        end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(0, 1'b1, 3'b111, 32'h8, 32'h12345678);
        #1;
        checks++;
        if (req_ready_0 !== 1'b1) begin
            failures++; $display("FAIL b2b_first_accept: got %b required 1", req_ready_0);
        end
        cyc();
        drive(0, 1'b1, 3'b010, 32'h8, 32'h0);
        #1;
        checks++;
        if ({req_ready_0, mem_write} !== 2'b01) begin
            failures++; $display("FAIL b2b_access: ready=%b wr=%b required 0 1", req_ready_0, mem_write);
        end
        cyc();
        #1;
        checks++;
        if ({rsp_valid_0, req_ready_0} !== 2'b11) begin
            failures++; $display("FAIL b2b_resp_accept: rsp=%b ready=%b required 1 1", rsp_valid_0, req_ready_0);
        end
        cyc();
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++;
        if (mem_read !== 1'b1) begin
            failures++; $display("FAIL b2b_load_read: got %b required 1", mem_read);
        end
        cyc();
        #1;
        checks++;
        if ({rsp_valid_0, rsp_rdata_0} !== {1'b1, 32'h12345678}) begin
            failures++; $display("FAIL b2b_load_data: rsp=%b rdata=%h required 1 12345678", rsp_valid_0, rsp_rdata_0);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_sign_ext();
        test_contention();
        test_errors();
        test_reset_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
